// File: rtl/pix_pkg.sv
// Shared pixel definitions: colour/coordinate widths, blend modes and the
// 36-bit packed frame-buffer word used by the writer and the sync_controller buffers.
package pix_pkg;

  localparam int R_W     = 5;
  localparam int G_W     = 6;
  localparam int B_W     = 5;
  localparam int COORD_W = 10;
  localparam int PIX_W   = 2 * COORD_W + R_W + G_W + B_W;

  localparam int B_LSB = 0;
  localparam int G_LSB = B_LSB + B_W;
  localparam int R_LSB = G_LSB + G_W;
  localparam int Y_LSB = R_LSB + R_W;
  localparam int X_LSB = Y_LSB + COORD_W;

  localparam logic [1:0] MODE_DVI   = 2'd0;
  localparam logic [1:0] MODE_CCD   = 2'd1;
  localparam logic [1:0] MODE_BLEND = 2'd2;
  localparam logic [1:0] MODE_DIFF  = 2'd3;

  // Same bit layout as pack_pix, for code that prefers named fields.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [R_W-1:0]     r;
    logic [G_W-1:0]     g;
    logic [B_W-1:0]     b;
  } pix_word_t;

  function automatic logic [4:0] clamp_alpha(input logic [4:0] alpha);
    return (alpha > 5'd16) ? 5'd16 : alpha;
  endfunction

  function automatic logic [PIX_W-1:0] pack_pix(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input logic [R_W-1:0]     r,
    input logic [G_W-1:0]     g,
    input logic [B_W-1:0]     b
  );
    logic [PIX_W-1:0] w;
    w = '0;
    w[X_LSB +: COORD_W] = x;
    w[Y_LSB +: COORD_W] = y;
    w[R_LSB +: R_W]     = r;
    w[G_LSB +: G_W]     = g;
    w[B_LSB +: B_W]     = b;
    return w;
  endfunction

endpackage

// File: rtl/pixel_blend_writer_if.sv
// Pixel stream from the sync/homography controller plus the frame-buffer
// write-FIFO port of pixel_blend_writer.
interface pixel_blend_writer_if;
  import pix_pkg::*;

  // val is a one-cycle strobe with no ready: the source never stalls, so the
  // sink must take every pixel. wrreq qualifies wrdata and a word transfers on
  // every rising clock edge where wrreq=1; wrreq is never raised while wrfull=1.
  logic               val;
  logic [COORD_W-1:0] sync_x;
  logic [COORD_W-1:0] sync_y;
  logic [R_W-1:0]     dvi_r;
  logic [G_W-1:0]     dvi_g;
  logic [B_W-1:0]     dvi_b;
  logic [R_W-1:0]     ccd_r;
  logic [G_W-1:0]     ccd_g;
  logic [B_W-1:0]     ccd_b;

  logic               wrclk;
  logic               wrreq;
  logic [PIX_W-1:0]   wrdata;
  logic               wrfull;

  modport master (
    output val, sync_x, sync_y, dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b, wrfull,
    input  wrclk, wrreq, wrdata
  );

  modport slave (
    input  val, sync_x, sync_y, dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b, wrfull,
    output wrclk, wrreq, wrdata
  );

endinterface

// File: rtl/pix_skid_fifo.sv
// Register-based FIFO that absorbs write-FIFO full periods; a push into a full
// FIFO is accepted only when a pop happens on the same edge.
module pix_skid_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_blend_writer.sv
// Blends DVI and warped CCD colour per pixel, packs it with its coordinates and
// writes it to the frame-buffer FIFO through a skid buffer; tracks frames and drops.
module pixel_blend_writer
  import pix_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int SKID_DEPTH = 4
) (
  input  logic                  clk_25,
  input  logic                  rst,
  pixel_blend_writer_if.slave   bus,
  input  logic [1:0]            mode,
  input  logic [4:0]            alpha,
  input  logic                  stats_clr,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(SKID_DEPTH) + 1;
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(SKID_DEPTH);
  localparam logic [COORD_W-1:0] LAST_X   = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] LAST_Y   = COORD_W'(V_ACTIVE - 1);

  logic [4:0]       a_eff;
  logic [4:0]       inv_a;
  logic [8:0]       sum_r;
  logic [9:0]       sum_g;
  logic [8:0]       sum_b;
  logic [R_W-1:0]   res_r;
  logic [G_W-1:0]   res_g;
  logic [B_W-1:0]   res_b;
  logic [PIX_W-1:0] blend_word;

  logic             s1_valid;
  logic [PIX_W-1:0] s1_word;

  logic [PIX_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             pop;
  logic             drop;
  logic             last_pop;

  // Weights always sum to 16, so the sums cannot exceed 16*max and fit 9/10 bits.
  always_comb begin
    a_eff = clamp_alpha(alpha);
    inv_a = 5'd16 - a_eff;
    sum_r = 9'(bus.ccd_r) * 9'(a_eff) + 9'(bus.dvi_r) * 9'(inv_a);
    sum_g = 10'(bus.ccd_g) * 10'(a_eff) + 10'(bus.dvi_g) * 10'(inv_a);
    sum_b = 9'(bus.ccd_b) * 9'(a_eff) + 9'(bus.dvi_b) * 9'(inv_a);
    res_r = bus.dvi_r;
    res_g = bus.dvi_g;
    res_b = bus.dvi_b;
    case (mode)
      MODE_DVI: ;
      MODE_CCD: begin
        res_r = bus.ccd_r;
        res_g = bus.ccd_g;
        res_b = bus.ccd_b;
      end
      MODE_BLEND: begin
        // All-zero CCD marks a warp outside the source image; keep DVI there.
        if ({bus.ccd_r, bus.ccd_g, bus.ccd_b} != '0) begin
          res_r = R_W'(sum_r >> 4);
          res_g = G_W'(sum_g >> 4);
          res_b = B_W'(sum_b >> 4);
        end
      end
      default: begin
        res_r = (bus.dvi_r > bus.ccd_r) ? bus.dvi_r - bus.ccd_r : bus.ccd_r - bus.dvi_r;
        res_g = (bus.dvi_g > bus.ccd_g) ? bus.dvi_g - bus.ccd_g : bus.ccd_g - bus.dvi_g;
        res_b = (bus.dvi_b > bus.ccd_b) ? bus.dvi_b - bus.ccd_b : bus.ccd_b - bus.dvi_b;
      end
    endcase
    blend_word = pack_pix(bus.sync_x, bus.sync_y, res_r, res_g, res_b);
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
    end else begin
      s1_valid <= bus.val;
      if (bus.val) s1_word <= blend_word;
    end
  end

  pix_skid_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk       (clk_25),
    .rst       (rst),
    .push      (s1_valid),
    .push_data (s1_word),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign pop        = ~fifo_empty & ~bus.wrfull;
  assign bus.wrreq  = pop;
  assign bus.wrdata = fifo_head;
  assign bus.wrclk  = clk_25;

  assign drop     = s1_valid & fifo_full & ~pop;
  assign last_pop = pop & (fifo_head[X_LSB +: COORD_W] == LAST_X)
                        & (fifo_head[Y_LSB +: COORD_W] == LAST_Y);

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= last_pop;
      if (last_pop) frame_cnt <= frame_cnt + 16'd1;
      if (stats_clr) begin
        drop_cnt <= '0;
        overflow <= 1'b0;
      end else if (drop) begin
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        overflow <= 1'b1;
      end
    end
  end

  assert property (@(posedge clk_25) disable iff (rst) fifo_full == (fifo_count == FULL_CNT));

endmodule

// File: tb/tb_pixel_blend_writer.sv
// Directed bench for pixel_blend_writer: literal checks on selected pixels plus
// a queue-level reference model compared against the outputs every cycle.
module tb_pixel_blend_writer;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int SKID_DEPTH = 4;
  localparam int W          = 36;

  logic        clk_25;
  logic        rst;
  logic [1:0]  mode;
  logic [4:0]  alpha;
  logic        stats_clr;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic        overflow;

  pixel_blend_writer_if bus ();

  pixel_blend_writer #(
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE),
    .SKID_DEPTH (SKID_DEPTH)
  ) dut (
    .clk_25     (clk_25),
    .rst        (rst),
    .bus        (bus),
    .mode       (mode),
    .alpha      (alpha),
    .stats_clr  (stats_clr),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_25 = 1'b0;
    forever #5 clk_25 = ~clk_25;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Colour rules written directly as integer arithmetic.
  function automatic logic [W-1:0] model_pix(int x, int y, int dr, int dg, int db,
                                             int cr, int cg, int cb, int m, int al);
    int a, r, g, b;
    logic [9:0] xx, yy;
    logic [4:0] rr, bb;
    logic [5:0] gg;
    a = (al > 16) ? 16 : al;
    r = dr; g = dg; b = db;
    case (m)
      1: begin r = cr; g = cg; b = cb; end
      2: if (!(cr == 0 && cg == 0 && cb == 0)) begin
           r = (cr * a + dr * (16 - a)) / 16;
           g = (cg * a + dg * (16 - a)) / 16;
           b = (cb * a + db * (16 - a)) / 16;
         end
      3: begin
           r = (dr > cr) ? dr - cr : cr - dr;
           g = (dg > cg) ? dg - cg : cg - dg;
           b = (db > cb) ? db - cb : cb - db;
         end
      default: ;
    endcase
    xx = 10'(x); yy = 10'(y); rr = 5'(r); gg = 6'(g); bb = 5'(b);
    return {xx, yy, rr, gg, bb};
  endfunction

  // Model state: pixel in flight (sampled at last edge) and buffered words.
  logic [W-1:0] exp_q[$];
  logic         d1_v;
  logic [W-1:0] d1_w;
  int           m_frame, m_drop;
  logic         m_ovf, m_fd;

  initial begin : compare
    logic [W-1:0] hd;
    logic         exp_wrreq;
    d1_v = 1'b0; d1_w = '0; m_frame = 0; m_drop = 0; m_ovf = 1'b0; m_fd = 1'b0;
    forever begin
      @(negedge clk_25);
      if (rst) begin
        exp_q.delete();
        d1_v = 1'b0; m_frame = 0; m_drop = 0; m_ovf = 1'b0; m_fd = 1'b0;
        chk("rst_wrreq", bus.wrreq, 0);
        chk("rst_wrdata", bus.wrdata, 0);
        chk("rst_outs", {frame_done, frame_cnt, drop_cnt, overflow}, 0);
      end else begin
        exp_wrreq = (exp_q.size() > 0) && !bus.wrfull;
        chk("m_wrreq", bus.wrreq, exp_wrreq);
        if (exp_q.size() > 0) chk("m_wrdata", bus.wrdata, exp_q[0]);
        chk("m_frame_done", frame_done, m_fd);
        chk("m_frame_cnt", frame_cnt, m_frame);
        chk("m_drop_cnt", drop_cnt, m_drop);
        chk("m_overflow", overflow, m_ovf);
        // advance to the state after the coming rising edge
        m_fd = 1'b0;
        if (exp_wrreq) begin
          hd = exp_q.pop_front();
          if (hd[35:26] == 10'(H_ACTIVE - 1) && hd[25:16] == 10'(V_ACTIVE - 1)) begin
            m_fd = 1'b1;
            m_frame = (m_frame + 1) % 65536;
          end
        end
        if (d1_v) begin
          if (exp_q.size() < SKID_DEPTH) exp_q.push_back(d1_w);
          else if (!stats_clr) begin
            if (m_drop < 65535) m_drop++;
            m_ovf = 1'b1;
          end
        end
        if (stats_clr) begin
          m_drop = 0;
          m_ovf = 1'b0;
        end
        d1_v = bus.val;
        if (bus.val)
          d1_w = model_pix(bus.sync_x, bus.sync_y, bus.dvi_r, bus.dvi_g, bus.dvi_b,
                           bus.ccd_r, bus.ccd_g, bus.ccd_b, mode, alpha);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_25);
    #2;
  endtask

  task automatic put(input int x, input int y, input int dr, input int dg, input int db,
                     input int cr, input int cg, input int cb);
    bus.val = 1'b1;
    bus.sync_x = 10'(x); bus.sync_y = 10'(y);
    bus.dvi_r = 5'(dr); bus.dvi_g = 6'(dg); bus.dvi_b = 5'(db);
    bus.ccd_r = 5'(cr); bus.ccd_g = 6'(cg); bus.ccd_b = 5'(cb);
    tick();
  endtask

  // Single pixel into an empty FIFO: write must appear exactly two cycles later.
  task automatic one_pix(input string nm, input int x, input int y, input int dr, input int dg,
                         input int db, input int cr, input int cg, input int cb,
                         input logic [W-1:0] exp);
    put(x, y, dr, dg, db, cr, cg, cb);
    bus.val = 1'b0;
    #1 chk({nm, "_early"}, bus.wrreq, 0);
    tick();
    #1 chk({nm, "_wrreq"}, bus.wrreq, 1);
    chk({nm, "_data"}, bus.wrdata, exp);
    tick();
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      #1 if (frame_done) pulses++;
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int pulses;
    rst = 1'b1; mode = 2'd0; alpha = 5'd0; stats_clr = 1'b0;
    bus.val = 1'b0; bus.wrfull = 1'b0;
    bus.sync_x = '0; bus.sync_y = '0;
    bus.dvi_r = '0; bus.dvi_g = '0; bus.dvi_b = '0;
    bus.ccd_r = '0; bus.ccd_g = '0; bus.ccd_b = '0;
    repeat (3) tick();
    chk("reset_state", {bus.wrreq, frame_done, frame_cnt, drop_cnt, overflow}, 0);
    rst = 1'b0;
    tick();

    // colour modes, literal expectations
    mode = 2'd0;
    one_pix("pass_dvi", 5, 7, 31, 63, 31, 0, 10, 0, {10'd5, 10'd7, 5'd31, 6'd63, 5'd31});
    mode = 2'd1;
    one_pix("pass_ccd", 8, 1, 1, 2, 3, 7, 8, 9, {10'd8, 10'd1, 5'd7, 6'd8, 5'd9});
    mode = 2'd2; alpha = 5'd8;
    one_pix("blend_a8", 1, 2, 0, 0, 0, 31, 63, 31, {10'd1, 10'd2, 5'd15, 6'd31, 5'd15});
    alpha = 5'd20;
    one_pix("blend_clamp", 3, 2, 0, 0, 0, 31, 63, 31, {10'd3, 10'd2, 5'd31, 6'd63, 5'd31});
    alpha = 5'd8;
    one_pix("blend_oob", 4, 2, 4, 4, 4, 0, 0, 0, {10'd4, 10'd2, 5'd4, 6'd4, 5'd4});
    alpha = 5'd5;
    one_pix("blend_trunc", 6, 2, 20, 40, 10, 4, 8, 30, {10'd6, 10'd2, 5'd15, 6'd30, 5'd16});
    alpha = 5'd0;
    one_pix("blend_a0", 7, 2, 9, 9, 9, 1, 1, 1, {10'd7, 10'd2, 5'd9, 6'd9, 5'd9});
    mode = 2'd3;
    one_pix("diff", 9, 9, 10, 20, 3, 12, 5, 3, {10'd9, 10'd9, 5'd2, 6'd15, 5'd0});

    // overflow: 7 pixels while write FIFO is full
    mode = 2'd0;
    bus.wrfull = 1'b1;
    for (int i = 0; i < 7; i++) put(100 + i, 10, i, i, i, 0, 0, 0);
    bus.val = 1'b0;
    repeat (3) tick();
    #1 chk("ovf_drop_cnt", drop_cnt, 3);
    chk("ovf_flag", overflow, 1);
    bus.wrfull = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_wrreq", bus.wrreq, 1);
      chk("drain_order", bus.wrdata[35:26], 100 + i);
      tick();
      #1;
    end
    chk("drain_done", bus.wrreq, 0);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    #1 chk("clr_drop_cnt", drop_cnt, 0);
    chk("clr_overflow", overflow, 0);

    // full FIFO, wrfull falls on the cycle of the next push: no drop
    bus.wrfull = 1'b1;
    for (int i = 0; i < 5; i++) put(200 + i, 11, 1, 1, 1, 0, 0, 0);
    bus.val = 1'b0;
    bus.wrfull = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("nodrop_wrreq", bus.wrreq, 1);
      chk("nodrop_order", bus.wrdata[35:26], 200 + i);
      tick();
      #1;
    end
    chk("nodrop_cnt", drop_cnt, 0);
    chk("nodrop_ovf", overflow, 0);

    // stats_clr coincides with a drop: clear wins
    bus.wrfull = 1'b1;
    for (int i = 0; i < 5; i++) put(300 + i, 12, 2, 2, 2, 0, 0, 0);
    bus.val = 1'b0;
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    #1 chk("clrwin_cnt", drop_cnt, 0);
    chk("clrwin_ovf", overflow, 0);
    bus.wrfull = 1'b0;
    repeat (6) tick();

    // frame completion on the last pixel only
    put(H_ACTIVE - 2, V_ACTIVE - 1, 3, 3, 3, 0, 0, 0);
    put(H_ACTIVE - 1, V_ACTIVE - 2, 3, 3, 3, 0, 0, 0);
    put(H_ACTIVE - 1, V_ACTIVE - 1, 3, 3, 3, 0, 0, 0);
    bus.val = 1'b0;
    count_pulses(8, pulses);
    chk("frame_pulses", pulses, 1);
    chk("frame_cnt_1", frame_cnt, 1);

    // a dropped last pixel completes no frame
    bus.wrfull = 1'b1;
    for (int i = 0; i < 4; i++) put(10 + i, 0, 4, 4, 4, 0, 0, 0);
    put(H_ACTIVE - 1, V_ACTIVE - 1, 4, 4, 4, 0, 0, 0);
    bus.val = 1'b0;
    tick();
    bus.wrfull = 1'b0;
    count_pulses(8, pulses);
    chk("droplast_pulses", pulses, 0);
    chk("droplast_frame_cnt", frame_cnt, 1);
    chk("droplast_drop_cnt", drop_cnt, 1);

    // reset mid-frame with buffered pixels
    bus.wrfull = 1'b1;
    for (int i = 0; i < 3; i++) put(20 + i, 5, 5, 5, 5, 0, 0, 0);
    bus.val = 1'b0;
    tick();
    bus.wrfull = 1'b0;
    #1 chk("pre_rst_wrreq", bus.wrreq, 1);
    rst = 1'b1;
    #1 chk("midrst_wrreq", bus.wrreq, 0);
    chk("midrst_wrdata", bus.wrdata, 0);
    chk("midrst_counters", {frame_cnt, drop_cnt, overflow, frame_done}, 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    #1 chk("post_rst_empty", bus.wrreq, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/pixel_blend_writer.md
Name: pixel_blend_writer

Overview:
- Downstream stage of the sync/homography controller.
- Consumes its per-pixel stream: val, sync_x/sync_y, 5-6-5 dvi_* and ccd_* colour.
- Combines DVI and CCD colour per a selectable mode (pass, alpha blend, difference) and packs the result with its coordinates into a 36-bit word for the frame-buffer write FIFO.
- The upstream has no backpressure, so a small skid FIFO absorbs write-FIFO full periods; overflow drops and counts pixels. Frame completion is reported.

Parameters:
- H_ACTIVE, 640, active pixels per line; last x = H_ACTIVE-1.
- V_ACTIVE, 480, active lines per frame; last y = V_ACTIVE-1.
- SKID_DEPTH, 4, skid FIFO entries (power of two, >=2).

Ports:
- clk_25  in  1  pixel clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- val  in  1  input pixel valid, one cycle per pixel.
- sync_x  in  10  pixel x.
- sync_y  in  10  pixel y.
- dvi_r / dvi_g / dvi_b  in  5/6/5  DVI colour.
- ccd_r / ccd_g / ccd_b  in  5/6/5  warped CCD colour.
- mode  in  2  0=DVI only, 1=CCD only, 2=alpha blend, 3=abs difference.
- alpha  in  5  CCD weight 0..16; values >16 are clamped to 16.
- stats_clr  in  1  synchronous clear of drop_cnt and overflow.
- wrfull  in  1  write FIFO full.
- wrclk  out  1  tied to clk_25.
- wrreq  out  1  write strobe.
- wrdata  out  36  {x[9:0], y[9:0], r[4:0], g[5:0], b[4:0]}.
- frame_done  out  1  one-cycle pulse on write of last pixel.
- frame_cnt  out  16  frames completed, wraps.
- drop_cnt  out  16  dropped pixels, saturates at 0xFFFF.
- overflow  out  1  sticky, set on first drop.

Behaviour:
- Clock and reset: one clock, clk_25; reset rst is asynchronous, active-high.
- Reset values: all outputs 0; pipeline valids 0; skid FIFO empty; all counters 0. Reset mid-operation discards in-flight and buffered pixels. There is no partial write: wrreq is deasserted immediately.
- Stage 1 (edge after val=1):
  - Registers x and y.
  - Registers the per-channel result, with mode and alpha sampled in the same cycle as val.
  - Mode 0: output = dvi. Mode 1: output = ccd.
  - Mode 2, with a = clamp(alpha):
    - out = (ccd*a + dvi*(16-a)) >> 4.
    - Intermediate sums are 9 bits for r/b and 10 bits for g; results are truncated, not rounded.
    - If ccd r, g and b are all 0 (out-of-bounds warp), out = dvi.
  - Mode 3: out = |dvi - ccd| per channel.
- Stage 2 (next edge): the packed word is pushed into the skid FIFO.
- Write side (combinational from FIFO state):
  - wrreq = ~empty & ~wrfull.
  - wrdata = FIFO head.
  - Pop on every cycle with wrreq=1.
  - Latency from val to wrreq is 2 cycles when the FIFO is empty and wrfull=0.
- Push with FIFO full:
  - If a pop occurs in the same cycle, push and pop both happen with no drop.
  - Otherwise the new word is dropped: drop_cnt += 1 (saturating) and overflow is set.
- Simultaneous stats_clr and drop: clear wins; the counter reads 0 next cycle and overflow stays 0.
- Frame tracking: on a pop where head x==H_ACTIVE-1 and y==V_ACTIVE-1:
  - frame_done=1 for one cycle, registered (the cycle after the pop).
  - frame_cnt increments and wraps from 0xFFFF to 0.
  - A dropped last pixel produces no frame_done.
- Back-to-back val every cycle is supported at full throughput while wrfull=0.

Decomposition:
- Shared package pix_pkg:
  - Colour widths R_W=5, G_W=6, B_W=5, COORD_W=10.
  - Mode constants MODE_DVI, MODE_CCD, MODE_BLEND, MODE_DIFF.
  - 36-bit packed pixel word layout and field offsets (also used by sync_controller buffers).
- One sub-module, pix_skid_fifo: register-based FIFO of width 36 and depth SKID_DEPTH.
  - Interfaces: push, pop, full, empty, count; simultaneous push and pop when full.
- Blend arithmetic and frame/statistics logic stay in the top module.

Test Plan:
- Mode 0, val one cycle with x=5, y=7, dvi=(31,63,31), ccd=(0,10,0), wrfull=0 -> wrreq exactly 2 cycles later, wrdata={5,7,31,63,31}.
- Mode 2, alpha=8, dvi=(0,0,0), ccd=(31,63,31) -> out=(15,31,15). alpha=20 -> treated as 16, out=(31,63,31). ccd=(0,0,0), dvi=(4,4,4) -> out=(4,4,4).
- Mode 3, dvi=(10,20,3), ccd=(12,5,3) -> out=(2,15,0).
- wrfull held 1 while 7 consecutive val pixels arrive -> 4 buffered, drop_cnt=3, overflow=1. Release wrfull -> 4 writes in consecutive cycles in original order. stats_clr -> drop_cnt=0, overflow=0.
- FIFO full, wrfull falls in the same cycle as a new push -> no drop, drop_cnt unchanged.
- Full 640x480 raster, with last pixel x=639, y=479 -> single frame_done pulse, frame_cnt=1. Assert rst mid-frame -> wrreq=0 immediately, all counters 0, FIFO empty.
